// File: rtl/dmem_arbiter.sv
// Data memory arbiter between the CPU EX/MEM stage and the NIC DMA port.
// Fixed CPU priority with a starvation window that hands the NIC a short burst.
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_LEN = 4,
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [63:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        nic_req,
    input  logic        nic_wr,
    input  logic [31:0] nic_addr,
    input  logic [63:0] nic_wdata,
    output logic        nic_gnt,
    output logic [63:0] nic_rdata,
    output logic        nic_rvalid,
    output logic        memEn,
    output logic        memWrEn,
    output logic [31:0] memAddr,
    output logic [63:0] dataOut,
    input  logic [63:0] dataIn
);

    typedef enum logic [0:0] {
        CPU_PRI = 1'b0,
        NIC_PRI = 1'b1
    } state_e;

    localparam logic [3:0]  MAX_W     = 4'(MAX_WAIT);
    localparam logic [3:0]  BURST_L   = 4'(BURST_LEN);
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] burst_q, burst_d;
    logic       tag_nic_q, tag_nic_d;
    logic       tag_rd_q, tag_rd_d;
    logic [3:0] wait_inc;
    logic [3:0] burst_inc;

    // Counters stop at all-ones instead of wrapping back to zero.
    assign wait_inc  = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
    assign burst_inc = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;

    // Arbitration: pick at most one requester and compute the next priority state.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        cpu_gnt = 1'b0;
        nic_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                CPU_PRI: begin
                    cpu_gnt = cpu_req;
                    nic_gnt = nic_req & ~cpu_req;
                    if (nic_req && !nic_gnt) begin
                        if (wait_inc >= MAX_W) begin
                            state_d = NIC_PRI;
                            wait_d  = 4'd0;
                            burst_d = 4'd0;
                        end else begin
                            wait_d = wait_inc;
                        end
                    end else begin
                        wait_d = 4'd0;
                    end
                end
                NIC_PRI: begin
                    nic_gnt = nic_req;
                    cpu_gnt = cpu_req & ~nic_req;
                    wait_d  = 4'd0;
                    if (!nic_req) begin
                        state_d = CPU_PRI;
                        burst_d = 4'd0;
                    end else if (burst_inc >= BURST_L) begin
                        state_d = CPU_PRI;
                        burst_d = 4'd0;
                    end else begin
                        burst_d = burst_inc;
                    end
                end
                default: begin
                    state_d = CPU_PRI;
                    wait_d  = 4'd0;
                    burst_d = 4'd0;
                end
            endcase
        end
    end

    // Read-return tag: who owns the command issued this cycle and whether it reads.
    always_comb begin
        tag_nic_d = nic_gnt;
        tag_rd_d  = (cpu_gnt & ~cpu_wr) | (nic_gnt & ~nic_wr);
    end

    // State, counters and tag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CPU_PRI;
            wait_q    <= 4'd0;
            burst_q   <= 4'd0;
            tag_nic_q <= 1'b0;
            tag_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            burst_q   <= burst_d;
            tag_nic_q <= tag_nic_d;
            tag_rd_q  <= tag_rd_d;
        end
    end

    // Memory command mux; everything idles at zero when nobody is granted.
    always_comb begin
        memEn   = cpu_gnt | nic_gnt;
        memWrEn = 1'b0;
        memAddr = '0;
        dataOut = '0;
        if (nic_gnt) begin
            memWrEn = nic_wr;
            memAddr = nic_addr & ADDR_MASK;
            dataOut = nic_wdata;
        end else if (cpu_gnt) begin
            memWrEn = cpu_wr;
            memAddr = cpu_addr & ADDR_MASK;
            dataOut = cpu_wdata;
        end
    end

    // Read data is shared; the valids steer it and are killed while in reset.
    always_comb begin
        cpu_rdata  = dataIn;
        nic_rdata  = dataIn;
        cpu_rvalid = ~reset & tag_rd_q & ~tag_nic_q;
        nic_rvalid = ~reset & tag_rd_q & tag_nic_q;
        cpu_stall  = ~reset & cpu_req & ~cpu_gnt;
    end

endmodule
